delay_ram_ctrl: RTL and testbench
=================================

Name: delay_ram_ctrl

Overview:
- Address and sequencing controller for a runtime-programmable delay line built on an external simple dual-port RAM of 2^AW words.
- Generates the RAM write and read strobes and addresses, plus an output-valid strobe.
- Generates a zero-force flag that blanks stale RAM contents while the line refills after reset or after a delay change.
- Sits between a sample source (din_valid strobes) and the RAM/output mux. It replaces fixed register delay lines where the delay must change at run time.

Parameters:
AW, 10, RAM address width; maximum delay 2^AW-1 samples
RL, 1, RAM read latency in clocks (1..4)
DEF_D, 16, delay loaded at reset (2 <= DEF_D <= 2^AW-1)

Ports:
clk  in  1  system clock
reset_b  in  1  asynchronous active-low reset
din_valid  in  1  one sample available this cycle
delay_in  in  AW  requested delay in samples
delay_ld  in  1  load delay_in this cycle
ram_we  out  1  RAM write enable
ram_waddr  out  AW  RAM write address
ram_re  out  1  RAM read enable
ram_raddr  out  AW  RAM read address
dout_valid  out  1  RAM read data valid this cycle
dout_zero  out  1  force output to zero (qualifies dout_valid)
busy  out  1  refill in progress (state FILL)
delay_cur  out  AW  delay currently in effect

Behaviour:
- Clock and reset: one clock, clk. reset_b is asynchronous and active-low.
- Reset values:
  - ram_we, ram_re, dout_valid, dout_zero = 0.
  - ram_waddr, ram_raddr, internal wptr, fill_cnt = 0.
  - delay_cur = DEF_D.
  - state = FILL, busy = 1.
- Strobe pipeline: a din_valid at cycle t produces ram_we=ram_re=1 at t+1 (registered).
  - ram_waddr = wptr.
  - ram_raddr = (wptr - delay_cur) mod 2^AW, using the delay in effect for that strobe.
  - wptr increments mod 2^AW after each strobe.
- Output timing: dout_valid is asserted at t+1+RL via an RL-deep shift pipeline. dout_zero travels in the same pipeline, aligned with dout_valid. dout_zero is 0 whenever dout_valid is 0.
- Delay semantics: the sample written at strobe k is read at strobe k+delay_cur (delay counted in strobes, not clocks). Gaps in din_valid do not change the delay.
- States:
  - FILL: each strobe is tagged dout_zero = (fill_cnt < delay_cur), then fill_cnt increments. When fill_cnt reaches delay_cur, the state moves to RUN on that same edge.
  - RUN: strobes are tagged dout_zero=0. busy=0. fill_cnt holds.
- delay_ld, accepted in any state:
  - delay_cur <= clamp(delay_in), where values 0 or 1 become 2.
  - fill_cnt <= 0, state <= FILL.
  - wptr is NOT reset.
- delay_ld together with din_valid in the same cycle:
  - The strobe uses the NEW delay for ram_raddr.
  - The strobe is tagged dout_zero=1 and counts as the first fill write (fill_cnt=1).
- delay_ld during FILL restarts the fill count from 0 under the new delay.
- Strobes already in the RL read pipeline are unaffected by delay_ld.
- delay_cur = 2^AW-1 is legal. The read address then equals wptr+1 mod 2^AW, the oldest RAM word.
- Wrap-around: all pointer arithmetic is modulo 2^AW with no special case.
- Reset mid-operation: all outputs clear immediately, asynchronously, including in-flight dout_valid. delay_cur returns to DEF_D.
- No throughput limit: din_valid may be high every cycle.

Test Plan:
- Settings for all scenarios: AW=4, RL=2, DEF_D=3.
- Reset release, then 8 back-to-back strobes:
  - ram_we/ram_re follow each din_valid by 1 clk, with waddr 0..7 and raddr 13,14,15,0..4.
  - dout_valid follows 3 clk after din_valid.
  - dout_zero=1 on the first 3 dout_valid only.
  - busy falls on the edge of the 3rd strobe.
- In RUN at wptr=8, delay_ld with delay_in=5 and no strobe, then 7 strobes:
  - delay_cur=5 next cycle.
  - raddr 3,4,5,..., with dout_zero=1 on the first 5 outputs and 0 afterwards.
  - busy high for exactly those 5 strobes.
- delay_ld=1 with delay_in=0 together with din_valid at wptr=4:
  - delay_cur=2.
  - That strobe gives raddr=2 and dout_zero=1.
  - Exactly one more zero-tagged output follows, then RUN.
- delay_in=15, then 20 strobes with random 0-3 cycle gaps:
  - raddr = wptr+1 mod 16 (e.g. wptr=15 gives raddr=0).
  - The first 15 outputs are zero-tagged.
  - Each dout_valid is exactly 3 clk after its din_valid regardless of gaps.
- reset_b pulsed low for half a cycle mid-FILL, with a strobe in the read pipeline:
  - All outputs are 0 within the same cycle and the pending dout_valid never appears.
  - delay_cur=3, wptr restarts at 0, busy=1.

Source files
------------

// File: rtl/delay_ram_ctrl.sv
// ---------------------------------------------------------------------------
// delay_ram_ctrl
//
// Address and sequencing controller for a runtime-programmable delay line
// built on an external simple dual-port RAM of 2^AW words. Each incoming
// sample strobe writes the RAM at the write pointer and reads the word that
// was written delay_cur strobes earlier. A zero-force flag travels with the
// read data and blanks stale RAM contents while the line refills after reset
// or after a delay change.
//
// Ports:
//   clk        in   system clock
//   reset_b    in   asynchronous active-low reset
//   din_valid  in   one sample available this cycle
//   delay_in   in   requested delay in samples (AW bits)
//   delay_ld   in   load delay_in this cycle
//   ram_we     out  RAM write enable
//   ram_waddr  out  RAM write address (AW bits)
//   ram_re     out  RAM read enable
//   ram_raddr  out  RAM read address (AW bits)
//   dout_valid out  RAM read data valid this cycle
//   dout_zero  out  force output to zero (qualifies dout_valid)
//   busy       out  refill in progress
//   delay_cur  out  delay currently in effect (AW bits)
// ---------------------------------------------------------------------------
module delay_ram_ctrl #(
   parameter int AW    = 10,
   parameter int RL    = 1,
   parameter int DEF_D = 16
) (
   input  logic          clk,
   input  logic          reset_b,
   input  logic          din_valid,
   input  logic [AW-1:0] delay_in,
   input  logic          delay_ld,
   output logic          ram_we,
   output logic [AW-1:0] ram_waddr,
   output logic          ram_re,
   output logic [AW-1:0] ram_raddr,
   output logic          dout_valid,
   output logic          dout_zero,
   output logic          busy,
   output logic [AW-1:0] delay_cur
);

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [AW-1:0] DEF_DLY = AW'(DEF_D);

   // Delays below 2 are raised to 2.
   function automatic logic [AW-1:0] clamp_dly(input logic [AW-1:0] d);
      return (d < AW'(2)) ? AW'(2) : d;
   endfunction

   state_e          state_q,     state_d;
   logic [AW-1:0]   delay_cur_q, delay_cur_d;
   logic [AW-1:0]   fill_cnt_q,  fill_cnt_d;
   logic [AW-1:0]   wptr_q,      wptr_d;
   logic [AW-1:0]   waddr_q,     waddr_d;
   logic [AW-1:0]   raddr_q,     raddr_d;
   logic            strobe_q;
   logic            zero_q,      zero_d;
   logic [RL-1:0]   vld_pipe_q;
   logic [RL-1:0]   zero_pipe_q;

   // A delay load takes effect before the strobe of the same cycle is
   // processed, so that strobe already sees the new delay and an empty fill.
   always_comb begin
      state_d     = state_q;
      delay_cur_d = delay_cur_q;
      fill_cnt_d  = fill_cnt_q;
      wptr_d      = wptr_q;
      waddr_d     = waddr_q;
      raddr_d     = raddr_q;
      zero_d      = 1'b0;

      if (delay_ld) begin
         delay_cur_d = clamp_dly(delay_in);
         fill_cnt_d  = '0;
         state_d     = FILL;
      end

      if (din_valid) begin
         waddr_d = wptr_q;
         raddr_d = wptr_q - delay_cur_d;
         wptr_d  = wptr_q + AW'(1);
         if (state_d == FILL) begin
            zero_d     = (fill_cnt_d < delay_cur_d);
            fill_cnt_d = fill_cnt_d + AW'(1);
            // The last stale word has just been read: leave FILL on this edge.
            if (fill_cnt_d == delay_cur_d) begin
               state_d = RUN;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q     <= FILL;
         delay_cur_q <= DEF_DLY;
         fill_cnt_q  <= '0;
         wptr_q      <= '0;
         waddr_q     <= '0;
         raddr_q     <= '0;
         strobe_q    <= 1'b0;
         zero_q      <= 1'b0;
         vld_pipe_q  <= '0;
         zero_pipe_q <= '0;
      end else begin
         state_q     <= state_d;
         delay_cur_q <= delay_cur_d;
         fill_cnt_q  <= fill_cnt_d;
         wptr_q      <= wptr_d;
         waddr_q     <= waddr_d;
         raddr_q     <= raddr_d;
         strobe_q    <= din_valid;
         zero_q      <= zero_d;
         // Read-latency pipeline: the zero tag rides with its read strobe.
         vld_pipe_q[0]  <= strobe_q;
         zero_pipe_q[0] <= zero_q;
         for (int i = 1; i < RL; i++) begin
            vld_pipe_q[i]  <= vld_pipe_q[i-1];
            zero_pipe_q[i] <= zero_pipe_q[i-1];
         end
      end
   end

   assign ram_we     = strobe_q;
   assign ram_re     = strobe_q;
   assign ram_waddr  = waddr_q;
   assign ram_raddr  = raddr_q;
   assign dout_valid = vld_pipe_q[RL-1];
   assign dout_zero  = zero_pipe_q[RL-1];
   assign busy       = (state_q == FILL);
   assign delay_cur  = delay_cur_q;

endmodule

// File: tb/tb_delay_ram_ctrl.sv
module tb_delay_ram_ctrl;

   localparam int AW    = 4;
   localparam int RL    = 2;
   localparam int DEF_D = 3;
   localparam int N     = 1 << AW;

   logic          clk       = 1'b0;
   logic          reset_b   = 1'b1;
   logic          din_valid = 1'b0;
   logic          delay_ld  = 1'b0;
   logic [AW-1:0] delay_in  = '0;
   logic          ram_we, ram_re, dout_valid, dout_zero, busy;
   logic [AW-1:0] ram_waddr, ram_raddr, delay_cur;

   int total   = 0;
   int bad     = 0;
   int rst_cnt = 0;

   delay_ram_ctrl #(.AW(AW), .RL(RL), .DEF_D(DEF_D)) dut (
      .clk        (clk),
      .reset_b    (reset_b),
      .din_valid  (din_valid),
      .delay_in   (delay_in),
      .delay_ld   (delay_ld),
      .ram_we     (ram_we),
      .ram_waddr  (ram_waddr),
      .ram_re     (ram_re),
      .ram_raddr  (ram_raddr),
      .dout_valid (dout_valid),
      .dout_zero  (dout_zero),
      .busy       (busy),
      .delay_cur  (delay_cur)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Delay line seen from outside: the n-th strobe since the last delay
   // change (the coinciding strobe counts as n=1) reads the word written
   // delay strobes earlier and is zero-tagged while n <= delay. Its output
   // appears RL edges after the write/read strobe.
   int  k = 0, seen = 0;
   int  m_d = DEF_D, m_w = 0, m_n = 0;
   bit  sch_v [64];
   bit  sch_z [64];
   bit  e_we, e_dv, e_dz;
   int  e_wa, e_ra;

   always @(posedge clk) begin
      if (!reset_b || seen != rst_cnt) begin
         seen = rst_cnt;
         m_d  = DEF_D;
         m_w  = 0;
         m_n  = 0;
         for (int i = 0; i < 64; i++) begin
            sch_v[i] = 1'b0;
            sch_z[i] = 1'b0;
         end
      end
      e_we = 1'b0;
      e_wa = 0;
      e_ra = 0;
      if (reset_b) begin
         if (delay_ld) begin
            m_d = (delay_in < 2) ? 2 : int'(delay_in);
            m_n = 0;
         end
         if (din_valid) begin
            e_we = 1'b1;
            e_wa = m_w;
            e_ra = (m_w - m_d + N) % N;
            if (m_n < 1000) m_n++;
            sch_v[(k + RL) % 64] = 1'b1;
            sch_z[(k + RL) % 64] = (m_n <= m_d);
            m_w = (m_w + 1) % N;
         end
      end
      e_dv = sch_v[k % 64];
      e_dz = sch_z[k % 64];
      sch_v[k % 64] = 1'b0;
      sch_z[k % 64] = 1'b0;
      k++;
      #1;
      chk("ram_we", ram_we, e_we);
      chk("ram_re", ram_re, e_we);
      if (e_we) begin
         chk("ram_waddr", ram_waddr, e_wa);
         chk("ram_raddr", ram_raddr, e_ra);
      end
      chk("dout_valid", dout_valid, e_dv);
      chk("dout_zero", dout_zero, e_dz);
      chk("busy", busy, (m_n < m_d));
      chk("delay_cur", delay_cur, m_d);
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit dv, input bit ld, input int din);
      @(negedge clk);
      din_valid = dv;
      delay_ld  = ld;
      delay_in  = AW'(din);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 0);
   endtask

   int gaps [20] = '{0, 3, 1, 2, 0, 0, 3, 1, 2, 1, 0, 2, 3, 0, 1, 1, 2, 0, 3, 1};

   initial begin
      #1 reset_b = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_we", ram_we, 0);
      chk("rst_re", ram_re, 0);
      chk("rst_waddr", ram_waddr, 0);
      chk("rst_raddr", ram_raddr, 0);
      chk("rst_dv", dout_valid, 0);
      chk("rst_dz", dout_zero, 0);
      chk("rst_busy", busy, 1);
      chk("rst_dcur", delay_cur, 3);
      @(negedge clk);
      reset_b = 1'b1;

      // back-to-back strobes under the default delay
      step(1'b1, 1'b0, 0);
      @(posedge clk); #2;
      chk("s1_first_raddr", ram_raddr, 13);
      chk("s1_first_waddr", ram_waddr, 0);
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      @(posedge clk); #2;
      chk("s1_busy_fall", busy, 0);
      repeat (5) step(1'b1, 1'b0, 0);
      idle(4);

      // delay change to 5 without a strobe, at wptr=8
      step(1'b0, 1'b1, 5);
      @(posedge clk); #2;
      chk("s2_dcur", delay_cur, 5);
      chk("s2_busy", busy, 1);
      step(1'b1, 1'b0, 0);
      @(posedge clk); #2;
      chk("s2_first_raddr", ram_raddr, 3);
      repeat (6) step(1'b1, 1'b0, 0);
      idle(4);
      repeat (5) step(1'b1, 1'b0, 0);
      idle(2);

      // delay_in=0 loaded together with a strobe at wptr=4
      step(1'b1, 1'b1, 0);
      @(posedge clk); #2;
      chk("s3_dcur", delay_cur, 2);
      chk("s3_raddr", ram_raddr, 2);
      chk("s3_waddr", ram_waddr, 4);
      repeat (3) step(1'b1, 1'b0, 0);
      idle(4);

      // maximum delay with gaps between strobes
      step(1'b0, 1'b1, 15);
      for (int i = 0; i < 20; i++) begin
         idle(gaps[i]);
         step(1'b1, 1'b0, 0);
         if (i == 0) begin
            @(posedge clk); #2;
            chk("s4_oldest_raddr", ram_raddr, 9);
         end
      end
      idle(5);

      // asynchronous reset mid-fill with reads in flight
      step(1'b0, 1'b1, 6);
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      @(posedge clk); #2;
      chk("s5_pre_we", ram_we, 1);
      reset_b   = 1'b0;
      din_valid = 1'b0;
      delay_ld  = 1'b0;
      rst_cnt++;
      #1;
      chk("s5_we", ram_we, 0);
      chk("s5_re", ram_re, 0);
      chk("s5_dv", dout_valid, 0);
      chk("s5_dz", dout_zero, 0);
      chk("s5_busy", busy, 1);
      chk("s5_dcur", delay_cur, 3);
      #4 reset_b = 1'b1;
      step(1'b1, 1'b0, 0);
      @(posedge clk); #2;
      chk("s5_waddr_restart", ram_waddr, 0);
      chk("s5_raddr_restart", ram_raddr, 13);
      repeat (3) step(1'b1, 1'b0, 0);
      idle(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
